// File: rtl/mult_pkg.sv
// Shared constants and types for the 16x9 unsigned multiplier datapath.
package mult_pkg;
   localparam int MD_WD   = 16;
   localparam int MR_WD   = 9;
   localparam int MDMR_WD = MD_WD + MR_WD;

   typedef logic [MDMR_WD-1:0] pp_row_t;
   typedef pp_row_t [0:MR_WD-1] pp_arr_t;

   typedef struct packed {
      pp_row_t sum;
      pp_row_t carry;
   } csa_out_t;
endpackage

// File: rtl/csa32.sv
// 3:2 carry-save compressor; carry is pre-shifted and truncated to W bits.
module csa32
   import mult_pkg::*;
#(
   parameter int W = MDMR_WD
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);
   logic [W-1:0] maj;

   assign sum   = a ^ b ^ c;
   assign maj   = (a & b) | (a & c) | (b & c);
   // Dropping the top majority bit is safe: the full product fits in W bits.
   assign carry = maj << 1;
endmodule

// File: rtl/pp_reduce.sv
// Three-stage partial-product reduction (CSA tree + CPA) with valid/ready.
// Optional PP_REDUCE_PERF_EN adds transfer and stall counters.
module pp_reduce
   import mult_pkg::*;
#(
   parameter int MD_WD   = 16,
   parameter int MR_WD   = 9,
   parameter int MDMR_WD = MD_WD + MR_WD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MDMR_WD-1:0] pp [0:MR_WD-1],
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MDMR_WD-1:0] product
`ifdef PP_REDUCE_PERF_EN
  ,output logic [15:0]        perf_done,
   output logic [15:0]        perf_stall
`endif
);
   if (MR_WD != 9) begin : g_bad_mr_wd
      $error("pp_reduce: only MR_WD == 9 is supported");
   end

   logic v1, v2, v3;
   logic adv1, adv2, adv3;

   assign adv3      = !v3 || out_ready;
   assign adv2      = !v2 || adv3;
   assign adv1      = !v1 || adv2;
   assign in_ready  = adv1;
   assign out_valid = v3;

   // S1: rows {0,1,2},{3,4,5},{6,7,8} -> six vectors
   logic [MDMR_WD-1:0] c1_sum [0:2];
   logic [MDMR_WD-1:0] c1_cry [0:2];
   logic [MDMR_WD-1:0] s1     [0:5];

   for (genvar g = 0; g < 3; g++) begin : g_s1
      csa32 #(.W(MDMR_WD)) u_csa (
         .a    (pp[3*g]),
         .b    (pp[3*g+1]),
         .c    (pp[3*g+2]),
         .sum  (c1_sum[g]),
         .carry(c1_cry[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         for (int i = 0; i < 6; i++) s1[i] <= '0;
      end else if (adv1) begin
         v1 <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
               s1[2*i]   <= c1_sum[i];
               s1[2*i+1] <= c1_cry[i];
            end
         end
      end
   end

   // S2: 6->4, 4->3 (one vector bypasses), 3->2
   logic [MDMR_WD-1:0] a_s, a_c, b_s, b_c, m_s, m_c, f_s, f_c;
   logic [MDMR_WD-1:0] s2_sum, s2_cry;

   csa32 #(.W(MDMR_WD)) u_csa_a (.a(s1[0]), .b(s1[1]), .c(s1[2]), .sum(a_s), .carry(a_c));
   csa32 #(.W(MDMR_WD)) u_csa_b (.a(s1[3]), .b(s1[4]), .c(s1[5]), .sum(b_s), .carry(b_c));
   csa32 #(.W(MDMR_WD)) u_csa_m (.a(a_s),   .b(a_c),   .c(b_s),   .sum(m_s), .carry(m_c));
   csa32 #(.W(MDMR_WD)) u_csa_f (.a(m_s),   .b(m_c),   .c(b_c),   .sum(f_s), .carry(f_c));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2     <= 1'b0;
         s2_sum <= '0;
         s2_cry <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            s2_sum <= f_s;
            s2_cry <= f_c;
         end
      end
   end

   // S3: carry-propagate add into the output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3      <= 1'b0;
         product <= '0;
      end else if (adv3) begin
         v3 <= v2;
         if (v2) product <= s2_sum + s2_cry;
      end
   end

`ifdef PP_REDUCE_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_done  <= '0;
         perf_stall <= '0;
      end else begin
         if (v3 && out_ready)  perf_done  <= perf_done + 16'd1;
         if (v3 && !out_ready) perf_stall <= perf_stall + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pp_reduce.sv
// Scoreboard bench for pp_reduce: stimulus pushes A*B, a negedge monitor pops on each output transfer.
module tb_pp_reduce;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [24:0] pp [0:8];
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [24:0] product;
`ifdef PP_REDUCE_PERF_EN
   logic [15:0] perf_done, perf_stall;
`endif

   pp_reduce dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pp       (pp),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product  (product)
`ifdef PP_REDUCE_PERF_EN
     ,.perf_done (perf_done),
      .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [24:0] exp_q [$];
   int          pop_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: an output transfer happens on the next rising edge
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {7'b0, product}, 32'hDEAD);
         end else begin
            chk("product", {7'b0, product}, {7'b0, exp_q.pop_front()});
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic set_rows(input logic [15:0] a, input logic [8:0] b);
      for (int i = 0; i < 9; i++) pp[i] = b[i] ? ({9'b0, a} << i) : 25'd0;
   endtask

   task automatic send(input logic [15:0] a, input logic [8:0] b);
      int n = 0;
      set_rows(a, b);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      exp_q.push_back({9'b0, a} * {16'b0, b});
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] a4;
      logic [8:0]  b4;
      set_rows(16'h0, 9'h0);
      #1 rst = 1'b1;
      #2;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_product", {7'b0, product}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // latency: product visible after the third rising edge counting the accept edge
      send(16'hFFFF, 9'h1FF);
      @(negedge clk); chk("lat_edge1_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk); chk("lat_edge2_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk); chk("lat_edge3_valid", {31'b0, out_valid}, 32'd1);
      chk("lat_product", {7'b0, product}, 32'h1FEFE01);
      drain();

      send(16'h04D2, 9'h100);
      send(16'h0000, 9'h1FF);
      send(16'hBEEF, 9'h000);
      drain();

      // back-to-back random traffic, one product per cycle
      pop_cyc.delete();
      for (int i = 0; i < 20; i++) send(16'($urandom), 9'($urandom));
      drain();
      chk("b2b_count", pop_cyc.size(), 32'd20);
      if (pop_cyc.size() == 20) chk("b2b_spacing", pop_cyc[19] - pop_cyc[0], 32'd19);

      // backpressure: three fill the pipe, the fourth waits
      out_ready = 1'b0;
      send(16'h1234, 9'h0A5);
      send(16'h8001, 9'h1FF);
      send(16'h00FF, 9'h101);
      a4 = 16'hCAFE; b4 = 9'h07B;
      set_rows(a4, b4);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_product", {7'b0, product}, 32'(25'h1234 * 25'h0A5));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      #1 chk("ready_return", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back({9'b0, a4} * {16'b0, b4});
      #1 in_valid = 1'b0;
      drain();

      // reset with two items in flight
      out_ready = 1'b0;
      send(16'h1111, 9'h003);
      send(16'h2222, 9'h005);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_product", {7'b0, product}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("no_stale_valid", {31'b0, out_valid}, 32'd0);
      send(16'h0ABC, 9'h1C3);
      drain();

`ifdef PP_REDUCE_PERF_EN
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) send(16'(i + 3), 9'(i + 7));
      drain();
      out_ready = 1'b0;
      send(16'h0777, 9'h0AA);
      begin
         int n = 0;
         @(negedge clk);
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("perf_wait_valid", {31'b0, out_valid}, 32'd1);
      end
      repeat (7) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("perf_done", {16'b0, perf_done}, 32'd5);
      chk("perf_stall", {16'b0, perf_stall}, 32'd7);
      force dut.perf_done = 16'hFFFF;
      #1 release dut.perf_done;
      send(16'h0002, 9'h003);
      drain();
      chk("perf_done_wrap", {16'b0, perf_done}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "watchdog");
   end
endmodule
